// File: rtl/mode_pkg.sv
// Shared encodings and defaults for the mode pacer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: 2-bit mode encodings, pacer FSM state type, default divisors,
//           prescaler width and a mode-to-LED helper.
package mode_pkg;

    localparam int PRESC_W = 27;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_EASY = 2'b01;
    localparam logic [1:0] MODE_MED  = 2'b10;
    localparam logic [1:0] MODE_HARD = 2'b11;

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_RUN = 1'b1
    } state_e;

    localparam int DEF_EASY_DIV = 50_000_000;
    localparam int DEF_MED_DIV  = 25_000_000;
    localparam int DEF_HARD_DIV = 10_000_000;

    localparam logic [7:0] TICK_CNT_MAX = 8'hFF;

    // One-hot indicator: off -> 0001, easy -> 0010, medium -> 0100, hard -> 1000.
    function automatic logic [3:0] mode_leds(input logic [1:0] mode);
        return 4'b0001 << mode;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Programmable prescaler: counts 0..div_i-1 while enabled and strobes wrap_o on the last count.
// Latency: wrap_o is combinational from the count register; the count restarts at the following edge.
// Backpressure: none; en_i low freezes the count, clr_i forces it to zero and masks the strobe.
// Ports: clock_i/reset_i (async active-high), clr_i, en_i, div_i[PRESC_W-1:0], wrap_o.
module tick_divider
    import mode_pkg::*;
(
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [PRESC_W-1:0] div_i,
    output logic               wrap_o
);

    localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;
    logic               at_end;

    always_comb begin
        // >= rather than == so a count left beyond the terminal value still wraps.
        at_end = (cnt_q >= (div_i - ONE));
        wrap_o = en_i & ~clr_i & at_end;

        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_end ? '0 : (cnt_q + ONE);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mode_pacer.sv
// Game pacer: emits a one-clock tick every DIV clocks of the selected mode and flags mode changes.
// Latency: mode_i is registered; change_o/leds_o/active_o follow one clock later, first tick DIV clocks after change_o.
// Backpressure: none; optional pause_i (macro MODE_PACER_PAUSE_EN) freezes pacing while in RUN.
// Ports: clock_i, reset_i (async active-high), mode_i[1:0], [pause_i],
//        tick_o, change_o, active_o, leds_o[3:0], tick_count_o[7:0] (saturating tick count since last change).
module mode_pacer
    import mode_pkg::*;
#(
    parameter int EASY_DIV = DEF_EASY_DIV,
    parameter int MED_DIV  = DEF_MED_DIV,
    parameter int HARD_DIV = DEF_HARD_DIV
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [1:0] mode_i,
`ifdef MODE_PACER_PAUSE_EN
    input  logic       pause_i,
`endif
    output logic       tick_o,
    output logic       change_o,
    output logic       active_o,
    output logic [3:0] leds_o,
    output logic [7:0] tick_count_o
);

    logic [1:0]         mode_q, mode_d;
    state_e             state_q, state_d;
    logic               change_q, change_d;
    logic               tick_q, tick_d;
    logic [7:0]         tick_count_q, tick_count_d;

    logic               mode_chg;
    logic               run;
    logic               paused;
    logic               presc_en;
    logic               presc_clr;
    logic               wrap;
    logic [PRESC_W-1:0] div_sel;

    // Divisor for the registered mode; the off entry is never used because the prescaler is held clear.
    always_comb begin
        div_sel = PRESC_W'(EASY_DIV);
        case (mode_q)
            MODE_EASY: div_sel = PRESC_W'(EASY_DIV);
            MODE_MED:  div_sel = PRESC_W'(MED_DIV);
            MODE_HARD: div_sel = PRESC_W'(HARD_DIV);
            default:   div_sel = PRESC_W'(EASY_DIV);
        endcase
    end

    always_comb begin
        mode_chg = (mode_i != mode_q);
        run      = (state_q == ST_RUN);
`ifdef MODE_PACER_PAUSE_EN
        paused   = pause_i;
`else
        paused   = 1'b0;
`endif
        // A change edge clears the prescaler and suppresses any coincident wrap.
        presc_en  = run & ~paused & ~mode_chg;
        presc_clr = mode_chg | ~run;
    end

    tick_divider u_tick_divider (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clr_i   (presc_clr),
        .en_i    (presc_en),
        .div_i   (div_sel),
        .wrap_o  (wrap)
    );

    always_comb begin
        mode_d       = mode_i;
        state_d      = state_q;
        change_d     = mode_chg;
        tick_d       = wrap;
        tick_count_d = tick_count_q;

        if (mode_chg) begin
            state_d      = (mode_i == MODE_OFF) ? ST_OFF : ST_RUN;
            tick_count_d = '0;
        end else if (wrap && (tick_count_q != TICK_CNT_MAX)) begin
            tick_count_d = tick_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            mode_q       <= MODE_OFF;
            state_q      <= ST_OFF;
            change_q     <= 1'b0;
            tick_q       <= 1'b0;
            tick_count_q <= '0;
        end else begin
            mode_q       <= mode_d;
            state_q      <= state_d;
            change_q     <= change_d;
            tick_q       <= tick_d;
            tick_count_q <= tick_count_d;
        end
    end

    assign tick_o       = tick_q;
    assign change_o     = change_q;
    assign active_o     = run;
    assign leds_o       = mode_leds(mode_q);
    assign tick_count_o = tick_count_q;

endmodule

// File: tb/tb_mode_pacer.sv
// Self-checking bench for mode_pacer with EASY_DIV=8, MED_DIV=4, HARD_DIV=2.
// Latency: n/a.
// Backpressure: n/a.
module tb_mode_pacer;

    localparam int EASY = 8;
    localparam int MED  = 4;
    localparam int HARD = 2;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic [1:0] mode = 2'b00;
`ifdef MODE_PACER_PAUSE_EN
    logic       pause = 1'b0;
`endif

    logic       tick_o;
    logic       change_o;
    logic       active_o;
    logic [3:0] leds_o;
    logic [7:0] tick_count_o;

    always #5 clk = ~clk;

    mode_pacer #(
        .EASY_DIV (EASY),
        .MED_DIV  (MED),
        .HARD_DIV (HARD)
    ) dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .mode_i       (mode),
`ifdef MODE_PACER_PAUSE_EN
        .pause_i      (pause),
`endif
        .tick_o       (tick_o),
        .change_o     (change_o),
        .active_o     (active_o),
        .leds_o       (leds_o),
        .tick_count_o (tick_count_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: counts clocks elapsed in the current mode and ticks on every multiple of the divisor.
    logic [1:0] m_mode;
    int         m_since;
    int         m_count;
    bit         m_tick;
    bit         m_change;

    function automatic int div_of(input logic [1:0] md);
        case (md)
            2'b01:   return EASY;
            2'b10:   return MED;
            2'b11:   return HARD;
            default: return 1;
        endcase
    endfunction

    task automatic model_reset();
        m_mode   = 2'b00;
        m_since  = 0;
        m_count  = 0;
        m_tick   = 1'b0;
        m_change = 1'b0;
    endtask

    task automatic model_edge();
        bit pz;
`ifdef MODE_PACER_PAUSE_EN
        pz = pause;
`else
        pz = 1'b0;
`endif
        if (mode != m_mode) begin
            m_mode   = mode;
            m_since  = 0;
            m_count  = 0;
            m_tick   = 1'b0;
            m_change = 1'b1;
        end else begin
            m_change = 1'b0;
            m_tick   = 1'b0;
            if (m_mode != 2'b00 && !pz) begin
                m_since++;
                if (m_since % div_of(m_mode) == 0) begin
                    m_tick = 1'b1;
                    if (m_count < 255) m_count++;
                end
            end
        end
    endtask

    // One clock: model follows the edge, outputs are then sampled 1ns later.
    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [3:0] exp_leds;
        exp_leds = 4'b0001 << m_mode;
        check({tag, " tick"},   tick_o,       m_tick);
        check({tag, " change"}, change_o,     m_change);
        check({tag, " active"}, active_o,     m_mode != 2'b00);
        check({tag, " leds"},   leds_o,       exp_leds);
        check({tag, " count"},  tick_count_o, m_count);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " tick"},   tick_o,       0);
        check({tag, " change"}, change_o,     0);
        check({tag, " active"}, active_o,     0);
        check({tag, " leds"},   leds_o,       4'b0001);
        check({tag, " count"},  tick_count_o, 0);
    endtask

    typedef struct {
        logic [1:0] mode;
        logic       tick;
        logic       change;
        logic       active;
        logic [3:0] leds;
        logic [7:0] cnt;
    } vec_t;

    vec_t vt[16];

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks;
        int q[$];
        int waited;

        // Easy divisor 8 then hard divisor 2, starting from off.
        vt[0]  = '{2'b00, 1'b0, 1'b0, 1'b0, 4'b0001, 8'd0};
        vt[1]  = '{2'b01, 1'b0, 1'b1, 1'b1, 4'b0010, 8'd0};
        vt[2]  = '{2'b01, 1'b0, 1'b0, 1'b1, 4'b0010, 8'd0};
        vt[3]  = '{2'b01, 1'b0, 1'b0, 1'b1, 4'b0010, 8'd0};
        vt[4]  = '{2'b01, 1'b0, 1'b0, 1'b1, 4'b0010, 8'd0};
        vt[5]  = '{2'b01, 1'b0, 1'b0, 1'b1, 4'b0010, 8'd0};
        vt[6]  = '{2'b01, 1'b0, 1'b0, 1'b1, 4'b0010, 8'd0};
        vt[7]  = '{2'b01, 1'b0, 1'b0, 1'b1, 4'b0010, 8'd0};
        vt[8]  = '{2'b01, 1'b0, 1'b0, 1'b1, 4'b0010, 8'd0};
        vt[9]  = '{2'b01, 1'b1, 1'b0, 1'b1, 4'b0010, 8'd1};
        vt[10] = '{2'b01, 1'b0, 1'b0, 1'b1, 4'b0010, 8'd1};
        vt[11] = '{2'b11, 1'b0, 1'b1, 1'b1, 4'b1000, 8'd0};
        vt[12] = '{2'b11, 1'b0, 1'b0, 1'b1, 4'b1000, 8'd0};
        vt[13] = '{2'b11, 1'b1, 1'b0, 1'b1, 4'b1000, 8'd1};
        vt[14] = '{2'b00, 1'b0, 1'b1, 1'b0, 4'b0001, 8'd0};
        vt[15] = '{2'b00, 1'b0, 1'b0, 1'b0, 4'b0001, 8'd0};

        // Reset state.
        model_reset();
        #1 rst = 1'b1;
        #10;
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Off for 50 cycles: never a tick.
        mode  = 2'b00;
        ticks = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (tick_o) ticks++;
            if (i % 10 == 0) check_model($sformatf("off c%0d", i));
        end
        check("off tick count", ticks, 0);
        check("off leds", leds_o, 4'b0001);
        check("off active", active_o, 0);

        // Directed vector table.
        for (int i = 0; i < 16; i++) begin
            mode = vt[i].mode;
            step();
            check($sformatf("vec%0d tick", i),   tick_o,       vt[i].tick);
            check($sformatf("vec%0d change", i), change_o,     vt[i].change);
            check($sformatf("vec%0d active", i), active_o,     vt[i].active);
            check($sformatf("vec%0d leds", i),   leds_o,       vt[i].leds);
            check($sformatf("vec%0d count", i),  tick_count_o, vt[i].cnt);
        end

        // Off -> easy: ticks 8, 16, 24 cycles after change_o.
        mode = 2'b01;
        step();
        check("easy change", change_o, 1);
        check("easy leds", leds_o, 4'b0010);
        q.delete();
        for (int c = 1; c <= 24; c++) begin
            step();
            check_model($sformatf("easy c%0d", c));
            if (tick_o) q.push_back(c);
        end
        check("easy tick n", q.size(), 3);
        if (q.size() == 3) begin
            check("easy tick0", q[0], 8);
            check("easy tick1", q[1], 16);
            check("easy tick2", q[2], 24);
        end

        // Five cycles after a tick switch to hard: partial easy period discarded.
        repeat (5) step();
        mode = 2'b11;
        step();
        check("e2h change", change_o, 1);
        check("e2h tick", tick_o, 0);
        check("e2h count", tick_count_o, 0);
        ticks = 0;
        for (int c = 1; c <= 6; c++) begin
            step();
            check_model($sformatf("hard c%0d", c));
            if (tick_o) ticks++;
        end
        check("hard ticks in 6", ticks, 3);

        // Change landing exactly on an easy wrap edge: no tick.
        mode = 2'b01;
        step();
        repeat (7) step();
        mode = 2'b10;
        step();
        check("wrapchg tick", tick_o, 0);
        check("wrapchg change", change_o, 1);
        check("wrapchg leds", leds_o, 4'b0100);

        // Saturation in hard mode, then cleared by a change.
        mode = 2'b11;
        step();
        for (int c = 0; c < 600; c++) begin
            step();
            if (c % 50 == 0) check_model($sformatf("sat c%0d", c));
        end
        check("sat count", tick_count_o, 255);
        step();
        check("sat hold", tick_count_o, 255);
        mode = 2'b10;
        step();
        check("sat clear count", tick_count_o, 0);
        check("sat clear change", change_o, 1);

        // Reset mid-period in medium.
        step();
        step();
        rst = 1'b1;
        #2;
        check_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        check("postrst change", change_o, 1);
        check("postrst leds", leds_o, 4'b0100);
        check_model("postrst");

`ifdef MODE_PACER_PAUSE_EN
        // Pause 10 cycles in medium: tick phase shifts by 10.
        waited = 0;
        while (!tick_o && waited < 20) begin
            step();
            waited++;
        end
        check("pause pre tick", tick_o, 1);
        pause = 1'b1;
        ticks = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            check_model($sformatf("pause c%0d", c));
            if (tick_o) ticks++;
        end
        check("pause ticks", ticks, 0);
        pause  = 1'b0;
        waited = 0;
        do begin
            step();
            waited++;
        end while (!tick_o && waited < 30);
        check("pause resume gap", waited + 10, 14);
`endif

        // Randomised run against the model.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(15, 0) == 0) mode = 2'($urandom_range(3, 0));
`ifdef MODE_PACER_PAUSE_EN
            if ($urandom_range(3, 0) == 0) pause = 1'($urandom_range(1, 0));
`endif
            if ($urandom_range(199, 0) == 0) begin
                rst = 1'b1;
                #2;
                model_reset();
                check_model($sformatf("rnd rst c%0d", c));
                @(posedge clk);
                #1 rst = 1'b0;
            end else begin
                step();
                check_model($sformatf("rnd c%0d", c));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
